// File: rtl/ioctl_sdram_writer_pkg.sv
// Shared widths, request FSM state and packed-word payload for the ioctl download writer.
package ioctl_sdram_writer_pkg;

   localparam int unsigned SDRAM_ADDR_WIDTH = 23;
   localparam int unsigned SDRAM_DATA_WIDTH = 32;
   localparam int unsigned IOCTL_ADDR_WIDTH = 25;

   typedef enum logic {
      ST_IDLE,
      ST_REQ
   } req_state_e;

   typedef struct packed {
      logic [SDRAM_ADDR_WIDTH-1:0] addr;
      logic [SDRAM_DATA_WIDTH-1:0] data;
   } sdram_word_t;

   // Replace one little-endian byte lane of a word.
   function automatic logic [SDRAM_DATA_WIDTH-1:0] insert_byte(
      input logic [SDRAM_DATA_WIDTH-1:0] word,
      input logic [1:0]                  lane,
      input logic [7:0]                  value
   );
      logic [SDRAM_DATA_WIDTH-1:0] res;
      res = word;
      res[{lane, 3'b000} +: 8] = value;
      return res;
   endfunction

endpackage

// File: rtl/ioctl_sdram_writer_word_fifo.sv
// Synchronous first-word-through FIFO; a push while full is accepted only if a pop frees a slot.
module word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 55
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_c_o,
   output logic             empty_c_o,
   output logic [WIDTH-1:0] head_c_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_c_o = (count_q == '0);
   assign full_c_o  = (count_q == CNT_W'(DEPTH));
   assign head_c_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop_i & ~empty_c_o;
      do_push  = push_i & (~full_c_o | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/ioctl_sdram_writer.sv
// Packs the HPS download byte stream into 32-bit words and writes them to SDRAM one request at a time.
module ioctl_sdram_writer
   import ioctl_sdram_writer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ADDR_OFFSET = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
   input  logic [7:0]                  ioctl_data,
   input  logic                        ioctl_wr,
   input  logic                        ioctl_download,
   output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
   output logic [SDRAM_DATA_WIDTH-1:0] sdram_data,
   output logic                        sdram_we,
   output logic                        sdram_req,
   input  logic                        sdram_ack,
   output logic                        busy,
   output logic                        overflow
);

   logic                        dl_q;
   logic                        flush_q, flush_d;
   logic [3:0]                  mask_q, mask_d;
   logic [SDRAM_ADDR_WIDTH-1:0] pack_addr_q, pack_addr_d;
   logic [SDRAM_DATA_WIDTH-1:0] pack_data_q, pack_data_d;
   logic                        overflow_q, overflow_d;
   req_state_e                  state_q, state_d;
   logic                        req_q, req_d;
   logic                        we_q, we_d;
   logic [SDRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [SDRAM_DATA_WIDTH-1:0] data_q, data_d;

   logic                        strobe;
   logic                        start_new;
   logic                        push;
   logic                        pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [SDRAM_ADDR_WIDTH-1:0] wa;
   logic [1:0]                  lane;
   logic [SDRAM_DATA_WIDTH-1:0] merged_data;
   logic [3:0]                  merged_mask;
   sdram_word_t                 push_word;
   sdram_word_t                 head_word;

   assign strobe = ioctl_wr & ioctl_download;
   assign lane   = ioctl_addr[1:0];
   assign wa     = ioctl_addr[IOCTL_ADDR_WIDTH-1:2] + SDRAM_ADDR_WIDTH'(ADDR_OFFSET);

   // Byte packer. flush_q marks a pack that must be pushed on the next cycle:
   // either the download just ended, or a lane-3 byte arrived in the same
   // cycle the previous pack was pushed (only one push per cycle).
   always_comb begin
      mask_d         = mask_q;
      pack_addr_d    = pack_addr_q;
      pack_data_d    = pack_data_q;
      flush_d        = dl_q & ~ioctl_download;
      push           = 1'b0;
      push_word.addr = pack_addr_q;
      push_word.data = pack_data_q;
      start_new      = ~(|mask_q) | flush_q;
      merged_data    = '0;
      merged_mask    = '0;

      if (flush_q && (|mask_q)) begin
         push   = 1'b1;
         mask_d = '0;
      end

      if (strobe) begin
         if (!start_new && (wa != pack_addr_q)) begin
            push      = 1'b1;
            start_new = 1'b1;
         end
         merged_data = insert_byte(start_new ? '0 : pack_data_q, lane, ioctl_data);
         merged_mask = (start_new ? 4'b0000 : mask_q) | (4'b0001 << lane);
         if ((lane == 2'd3) && !push) begin
            push           = 1'b1;
            push_word.addr = wa;
            push_word.data = merged_data;
            mask_d         = '0;
         end else begin
            pack_addr_d = wa;
            pack_data_d = merged_data;
            mask_d      = merged_mask;
            if (lane == 2'd3) flush_d = 1'b1;
         end
      end
   end

   assign overflow_d = overflow_q | (push & fifo_full & ~pop);

   word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(sdram_word_t))
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_word),
      .pop_i       (pop),
      .full_c_o    (fifo_full),
      .empty_c_o   (fifo_empty),
      .head_c_o    (head_word)
   );

   // Request FSM: one outstanding write, held stable until acknowledged.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop     = 1'b0;
      if (state_q == ST_IDLE) begin
         if (!fifo_empty) begin
            addr_d  = head_word.addr;
            data_d  = head_word.data;
            req_d   = 1'b1;
            we_d    = 1'b1;
            pop     = 1'b1;
            state_d = ST_REQ;
         end
      end else begin
         if (sdram_ack) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dl_q        <= 1'b0;
         flush_q     <= 1'b0;
         mask_q      <= '0;
         pack_addr_q <= '0;
         pack_data_q <= '0;
         overflow_q  <= 1'b0;
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         dl_q        <= ioctl_download;
         flush_q     <= flush_d;
         mask_q      <= mask_d;
         pack_addr_q <= pack_addr_d;
         pack_data_q <= pack_data_d;
         overflow_q  <= overflow_d;
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   assign sdram_addr = addr_q;
   assign sdram_data = data_q;
   assign sdram_we   = we_q;
   assign sdram_req  = req_q;
   assign overflow   = overflow_q;
   assign busy       = ioctl_download | ~fifo_empty | req_q | (|mask_q) | flush_q;

endmodule

// File: tb/tb_ioctl_sdram_writer.sv
// Bench for ioctl_sdram_writer: two instances (offset 0 and 0x7FFFFF) share one stimulus and ack.
module tb_ioctl_sdram_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        ioctl_download;
   logic        ack;

   logic [22:0] addr0, addr1;
   logic [31:0] data0, data1;
   logic        we0, we1, req0, req1, busy0, busy1, ovf0, ovf1;

   int n_checks = 0;
   int n_pass   = 0;
   bit hold     = 1'b0;

   logic [54:0] obs0[$], obs1[$], exp0[$], exp1[$];

   // Reference packer state: the word currently being collected.
   logic [22:0] m_wa;
   logic [31:0] m_data;
   bit          m_have;

   always #5 clk = ~clk;

   ioctl_sdram_writer #(.FIFO_DEPTH(4), .ADDR_OFFSET(0)) dut0 (
      .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
      .sdram_addr(addr0), .sdram_data(data0), .sdram_we(we0), .sdram_req(req0),
      .sdram_ack(ack), .busy(busy0), .overflow(ovf0)
   );

   ioctl_sdram_writer #(.FIFO_DEPTH(4), .ADDR_OFFSET(23'h7FFFFF)) dut1 (
      .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
      .sdram_addr(addr1), .sdram_data(data1), .sdram_we(we1), .sdram_req(req1),
      .sdram_ack(ack), .busy(busy1), .overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
   endtask

   task automatic m_emit();
      logic [22:0] a1;
      a1 = m_wa + 23'h7FFFFF;
      exp0.push_back({m_wa, m_data});
      exp1.push_back({a1, m_data});
      m_have = 1'b0;
      m_data = '0;
   endtask

   task automatic m_byte(input logic [24:0] a, input logic [7:0] d);
      int lane;
      lane = int'(a[1:0]);
      if (m_have && (a[24:2] != m_wa)) m_emit();
      if (!m_have) begin
         m_wa   = a[24:2];
         m_data = '0;
         m_have = 1'b1;
      end
      m_data[lane*8 +: 8] = d;
      if (lane == 3) m_emit();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d, input int gap);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      m_byte(a, d);
      repeat (gap) tick();
   endtask

   task automatic end_download();
      ioctl_download = 1'b0;
      if (m_have) m_emit();
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((busy0 || busy1) && (n < 400)) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, 64'(busy0 | busy1), 64'(0));
   endtask

   task automatic cmp(input string tag);
      chk({tag, "_count0"}, 64'(obs0.size()), 64'(exp0.size()));
      for (int i = 0; i < obs0.size() && i < exp0.size(); i++)
         chk($sformatf("%s_word0_%0d", tag, i), 64'(obs0[i]), 64'(exp0[i]));
      chk({tag, "_count1"}, 64'(obs1.size()), 64'(exp1.size()));
      for (int i = 0; i < obs1.size() && i < exp1.size(); i++)
         chk($sformatf("%s_word1_%0d", tag, i), 64'(obs1[i]), 64'(exp1[i]));
      obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
   endtask

   // SDRAM controller stand-in: acks after 0..2 cycles unless held off.
   initial begin
      int d;
      ack = 1'b0;
      forever begin
         tick();
         if (!reset && req0 && !hold) begin
            d = $urandom_range(0, 2);
            repeat (d) tick();
            if (!reset && !hold && req0) begin
               chk("we_with_req", 64'({we0, we1}), 64'(2'b11));
               obs0.push_back({addr0, data0});
               obs1.push_back({addr1, data1});
               ack = 1'b1;
               tick();
               ack = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [24:0] base;
      int          len;
      reset = 1'b1; ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
      m_wa = '0; m_data = '0; m_have = 1'b0;
      repeat (3) tick();

      // Reset state; busy follows ioctl_download.
      chk("rst_req", 64'(req0), 64'(0));
      chk("rst_we", 64'(we0), 64'(0));
      chk("rst_addr", 64'(addr0), 64'(0));
      chk("rst_data", 64'(data0), 64'(0));
      chk("rst_ovf", 64'({ovf0, ovf1}), 64'(0));
      chk("rst_busy_lo", 64'({busy0, busy1}), 64'(0));
      ioctl_download = 1'b1;
      #1;
      chk("rst_busy_hi", 64'({busy0, busy1}), 64'(2'b11));
      ioctl_download = 1'b0;
      reset = 1'b0;
      tick();

      // Full word at 0..3, request two cycles after the lane-3 strobe.
      ioctl_download = 1'b1;
      tick();
      send(25'h0, 8'h11, 0);
      send(25'h1, 8'h22, 0);
      send(25'h2, 8'h33, 0);
      send(25'h3, 8'h44, 0);
      chk("t1_req_n", 64'(req0), 64'(0));
      tick();
      chk("t1_req_n1", 64'({req0, req1}), 64'(2'b11));
      chk("t1_addr", 64'(addr0), 64'(23'h000000));
      chk("t1_data", 64'(data0), 64'(32'h44332211));
      chk("t1_addr_off", 64'(addr1), 64'(23'h7FFFFF));
      end_download();
      wait_idle("t1");
      cmp("t1");

      // Partial word flushed at download end.
      ioctl_download = 1'b1;
      tick();
      send(25'h100, 8'hAA, 0);
      send(25'h101, 8'hBB, 0);
      end_download();
      tick();
      chk("t2_req_k", 64'(req0), 64'(0));
      tick();
      chk("t2_req_k1", 64'(req0), 64'(0));
      tick();
      chk("t2_req_k2", 64'(req0), 64'(1));
      chk("t2_addr", 64'(addr0), 64'(23'h000040));
      chk("t2_data", 64'(data0), 64'(32'h0000BBAA));
      wait_idle("t2");
      cmp("t2");

      // Address change pushes the old partial word.
      ioctl_download = 1'b1;
      tick();
      send(25'h8, 8'h5A, 1);
      send(25'h10, 8'h7E, 1);
      end_download();
      wait_idle("t3");
      cmp("t3");

      // Ack held off while 6 words arrive: 1 in flight + 4 buffered, 6th dropped.
      hold = 1'b1;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 24; i++) send(25'h200 + 25'(i), 8'($urandom), 1);
      end_download();
      repeat (10) tick();
      chk("t4_ovf", 64'({ovf0, ovf1}), 64'(2'b11));
      void'(exp0.pop_back());
      void'(exp1.pop_back());
      hold = 1'b0;
      wait_idle("t4");
      chk("t4_ovf_sticky", 64'(ovf0), 64'(1));
      cmp("t4");

      // Offset wrap: word 0 -> 0x7FFFFF, word 1 -> 0x000000 on the offset instance.
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) send(25'(i), 8'($urandom), 1);
      end_download();
      wait_idle("t5");
      cmp("t5");

      // Reset mid-request with two words buffered.
      hold = 1'b1;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) send(25'h300 + 25'(i), 8'($urandom), 0);
      repeat (2) tick();
      chk("t6_req_before", 64'(req0), 64'(1));
      reset = 1'b1;
      ioctl_download = 1'b0;
      tick();
      chk("t6_req", 64'({req0, req1}), 64'(0));
      chk("t6_we", 64'({we0, we1}), 64'(0));
      chk("t6_addr", 64'(addr0), 64'(0));
      chk("t6_data", 64'(data0), 64'(0));
      chk("t6_ovf", 64'({ovf0, ovf1}), 64'(0));
      chk("t6_busy", 64'({busy0, busy1}), 64'(0));
      reset = 1'b0;
      obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
      m_have = 1'b0; m_data = '0;
      hold = 1'b0;
      repeat (20) tick();
      chk("t6_no_req", 64'(obs0.size()), 64'(0));
      chk("t6_req_after", 64'(req0), 64'(0));

      // Random runs of sequential bytes at random start addresses.
      ioctl_download = 1'b1;
      tick();
      for (int r = 0; r < 25; r++) begin
         base = 25'($urandom);
         len  = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) send(base + 25'(j), 8'($urandom), 3);
      end
      end_download();
      wait_idle("t7");
      chk("t7_ovf", 64'({ovf0, ovf1}), 64'(0));
      cmp("t7");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
